// File: rtl/otter_icache_defs.sv
// rtl/otter_icache_defs.sv - shared definitions for the instruction cache fill controller
//
// Purpose: FSM state encoding, the nop instruction returned on a miss, and the
// address-field width derivations used by every file of the cache.
// Ports: none (package).
package otter_icache_defs;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Word-offset field width for a given line size in words.
  function automatic int calc_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Index field width for a given number of lines.
  function automatic int calc_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - data, tag and valid storage for the direct-mapped icache
//
// Purpose: holds one tag, one valid bit and WORDS_PER_LINE data words per line.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset (valid bits only)
//   i_rd_idx, i_rd_off       async lookup address -> o_rd_data, o_rd_tag, o_rd_valid
//   i_wr_en, i_wr_idx,
//   i_wr_off, i_wr_data      synchronous word write during a fill
//   i_line_done, i_line_tag  write tag of line i_wr_idx and mark it valid
//   i_inval_en, i_inval_idx  mark one line invalid (fill start)
//   i_clear_all              clear every valid bit
module icache_line_array
  import otter_icache_defs::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int TAG_W          = 23,
  localparam int OFF_W = calc_off_w(WORDS_PER_LINE),
  localparam int IDX_W = calc_idx_w(NUM_LINES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFF_W-1:0] i_rd_off,
  output logic [31:0]      o_rd_data,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic             o_rd_valid,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [OFF_W-1:0] i_wr_off,
  input  logic [31:0]      i_wr_data,
  input  logic             i_line_done,
  input  logic [TAG_W-1:0] i_line_tag,
  input  logic             i_inval_en,
  input  logic [IDX_W-1:0] i_inval_idx,
  input  logic             i_clear_all
);

  logic [31:0]          r_data [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_line_done) begin
      r_tag[i_wr_idx] <= i_line_tag;
    end
  end

  // Clear-all dominates a same-cycle line completion so fence.i always wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear_all) begin
      r_valid <= '0;
    end else begin
      if (i_inval_en) begin
        r_valid[i_inval_idx] <= 1'b0;
      end
      if (i_line_done) begin
        r_valid[i_wr_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - direct-mapped instruction cache with in-order line fill
//
// Purpose: serves fetch hits combinationally; on a miss stalls the front end and
// fills the whole line word 0 first from instruction memory, then re-looks-up.
// Ports:
//   CLK, RST_N     clock, synchronous active-low reset
//   PC, RD_EN      fetch byte address and request
//   INVALIDATE     fence.i: clear all valid bits (aborts a fill in progress)
//   INSTR          fetched word, nop whenever the lookup misses
//   STALLED        fetch not served this cycle
//   MEM_ADDR,
//   MEM_RDEN       word-aligned fill address and read request
//   MEM_DOUT,
//   MEM_VALID      fill data and its qualifier
module icache_fill_ctrl
  import otter_icache_defs::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC,
  input  logic              RD_EN,
  input  logic              INVALIDATE,
  output logic [31:0]       INSTR,
  output logic              STALLED,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RDEN,
  input  logic [31:0]       MEM_DOUT,
  input  logic              MEM_VALID
);

  localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
  localparam int IDX_W = calc_idx_w(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [OFF_W-1:0] r_cnt;
  logic [TAG_W-1:0] r_fill_tag;
  logic [IDX_W-1:0] r_fill_idx;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_rd_data;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_valid;
  logic             w_hit;
  logic             w_fill_active;
  logic             w_last;
  logic             w_start;
  logic             w_beat;
  logic             w_line_done;
  logic             w_unused_pc_lsb;

  assign w_off = PC[OFF_W+1:2];
  assign w_idx = PC[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag = PC[ADDR_W-1:IDX_W+OFF_W+2];
  // Byte offset within a word has no meaning for 32-bit fetches.
  assign w_unused_pc_lsb = &{1'b0, PC[1:0]};

  // Gating with RST_N keeps the outputs quiet while reset is held, even
  // before the first reset edge has reached the state register.
  assign w_hit         = RST_N & RD_EN & w_rd_valid & (w_rd_tag == w_tag);
  assign w_fill_active = RST_N & (r_state == FILL);
  assign w_last        = (r_cnt == LAST_CNT);
  assign w_start       = RST_N & (r_state == IDLE) & RD_EN & !w_hit & !INVALIDATE;
  assign w_beat        = w_fill_active & MEM_VALID & !INVALIDATE;
  assign w_line_done   = w_beat & w_last;

  assign INSTR    = w_hit ? w_rd_data : NOP;
  assign STALLED  = w_fill_active | (RD_EN & !w_hit);
  assign MEM_RDEN = w_fill_active;
  assign MEM_ADDR = w_fill_active ? {r_fill_tag, r_fill_idx, r_cnt, 2'b00} : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_start) w_next_state = FILL;
      FILL: if (INVALIDATE || (MEM_VALID && w_last)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_fill_tag <= w_tag;
      r_fill_idx <= w_idx;
    end else if (r_state == FILL) begin
      if (INVALIDATE) begin
        r_cnt <= '0;
      end else if (MEM_VALID) begin
        r_cnt <= r_cnt + OFF_W'(1);
      end
    end
  end

  icache_line_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_lines (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_rd_idx    (w_idx),
    .i_rd_off    (w_off),
    .o_rd_data   (w_rd_data),
    .o_rd_tag    (w_rd_tag),
    .o_rd_valid  (w_rd_valid),
    .i_wr_en     (w_beat),
    .i_wr_idx    (r_fill_idx),
    .i_wr_off    (r_cnt),
    .i_wr_data   (MEM_DOUT),
    .i_line_done (w_line_done),
    .i_line_tag  (r_fill_tag),
    .i_inval_en  (w_start),
    .i_inval_idx (w_idx),
    .i_clear_all (INVALIDATE)
  );

endmodule
